// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall controller: RAW (Tuse/Tnew) hazards against E and M plus HI/LO unit occupancy.
// Optional stall-cycle counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_stall_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10,
   parameter int unsigned CNT_W       = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       d_rs,
   input  logic [4:0]       d_rt,
   input  logic [1:0]       d_tuse_rs,
   input  logic [1:0]       d_tuse_rt,
   input  logic             d_md_use,
   input  logic [4:0]       e_wa,
   input  logic [1:0]       e_tnew,
   input  logic             e_md_start,
   input  logic             e_md_div,
   output logic             stall,
   output logic             pc_en,
   output logic             fd_en,
   output logic             md_busy,
   output logic [1:0]       md_state,
   output logic [CNT_W-1:0] busy_cnt,
   output logic [31:0]      stall_count
);

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StMulBusy = 2'd1,
      StDivBusy = 2'd2
   } md_state_e;

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       m_wa_q;
   logic [1:0]       m_tnew_q, m_tnew_d;
   logic             haz_e, haz_m, haz_md;

   // E->M never stalls, so the M tracker simply follows E every cycle.
   assign m_tnew_d = (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_wa_q   <= 5'd0;
         m_tnew_q <= 2'd0;
      end else begin
         m_wa_q   <= e_wa;
         m_tnew_q <= m_tnew_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (e_md_start) begin
               if (e_md_div) begin
                  state_d = StDivBusy;
                  cnt_d   = CNT_W'(DIV_CYCLES);
               end else begin
                  state_d = StMulBusy;
                  cnt_d   = CNT_W'(MULT_CYCLES);
               end
            end
         end
         StMulBusy, StDivBusy: begin
            // A start while busy is a protocol error and is ignored.
            if (cnt_q == CNT_W'(1)) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      haz_e = ((d_rs == e_wa) && (e_wa != 5'd0) && (d_tuse_rs < e_tnew)) ||
              ((d_rt == e_wa) && (e_wa != 5'd0) && (d_tuse_rt < e_tnew));
      haz_m = ((d_rs == m_wa_q) && (m_wa_q != 5'd0) && (d_tuse_rs < m_tnew_q)) ||
              ((d_rt == m_wa_q) && (m_wa_q != 5'd0) && (d_tuse_rt < m_tnew_q));
   end

   // The start cycle itself already counts as busy.
   assign md_busy  = e_md_start | (state_q != StIdle);
   assign haz_md   = d_md_use & md_busy;
   assign stall    = haz_e | haz_m | haz_md;
   assign pc_en    = ~stall;
   assign fd_en    = ~stall;
   assign md_state = state_q;
   assign busy_cnt = cnt_q;

`ifdef PIPE_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= 32'd0;
      end else if (stall) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_count = stall_cnt_q;
`else
   assign stall_count = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with hand-computed expectations.
module tb_pipe_stall_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  d_rs, d_rt, e_wa;
   logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew;
   logic        d_md_use, e_md_start, e_md_div;
   logic        stall, pc_en, fd_en, md_busy;
   logic [1:0]  md_state;
   logic [3:0]  busy_cnt;
   logic [31:0] stall_count;

   int checks   = 0;
   int failures = 0;

   pipe_stall_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .d_rs        (d_rs),
      .d_rt        (d_rt),
      .d_tuse_rs   (d_tuse_rs),
      .d_tuse_rt   (d_tuse_rt),
      .d_md_use    (d_md_use),
      .e_wa        (e_wa),
      .e_tnew      (e_tnew),
      .e_md_start  (e_md_start),
      .e_md_div    (e_md_div),
      .stall       (stall),
      .pc_en       (pc_en),
      .fd_en       (fd_en),
      .md_busy     (md_busy),
      .md_state    (md_state),
      .busy_cnt    (busy_cnt),
      .stall_count (stall_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_d();
      d_rs = 5'd0; d_rt = 5'd0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
      e_wa = 5'd0; e_tnew = 2'd0;
   endtask

   initial begin
      reset = 1'b0;
      clear_d();
      d_md_use = 1'b0; e_md_start = 1'b0; e_md_div = 1'b0;
      #1;
      chk("rst_state", {30'd0, md_state}, 32'd0);
      chk("rst_cnt", {28'd0, busy_cnt}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_pc_en", {31'd0, pc_en}, 32'd1);
      chk("rst_scount", stall_count, 32'd0);
      #21 reset = 1'b1;

      // Divide, ignored restart, then asynchronous reset mid-sequence.
      step();
      e_md_start = 1'b1; e_md_div = 1'b1; #1;
      chk("div_t_busy", {31'd0, md_busy}, 32'd1);
      chk("div_t_nouse_stall", {31'd0, stall}, 32'd0);
      step(); e_md_start = 1'b0; #1;
      chk("div_t1_state", {30'd0, md_state}, 32'd2);
      chk("div_t1_cnt", {28'd0, busy_cnt}, 32'd10);
      step(); #1;
      chk("div_t2_cnt", {28'd0, busy_cnt}, 32'd9);
      step(); e_md_start = 1'b1; e_md_div = 1'b0; #1;
      chk("div_t3_cnt", {28'd0, busy_cnt}, 32'd8);
      step(); e_md_start = 1'b0; #1;
      chk("div_t4_norel", {28'd0, busy_cnt}, 32'd7);
      chk("div_t4_state", {30'd0, md_state}, 32'd2);
      reset = 1'b0; #1;
      chk("async_rst_state", {30'd0, md_state}, 32'd0);
      chk("async_rst_cnt", {28'd0, busy_cnt}, 32'd0);
      #2 reset = 1'b1;
      step();
      chk("post_rst_busy", {31'd0, md_busy}, 32'd0);
      chk("post_rst_state", {30'd0, md_state}, 32'd0);

      // Load-use via rs with Tuse 0: stalls against E, then against M.
      e_wa = 5'd8; e_tnew = 2'd2; d_rs = 5'd8; d_tuse_rs = 2'd0; #1;
      chk("lu_e_stall", {31'd0, stall}, 32'd1);
      chk("lu_e_pc_en", {31'd0, pc_en}, 32'd0);
      chk("lu_e_fd_en", {31'd0, fd_en}, 32'd0);
      step(); e_wa = 5'd0; e_tnew = 2'd0; #1;
      chk("lu_m_stall", {31'd0, stall}, 32'd1);
      step(); #1;
      chk("lu_w_stall", {31'd0, stall}, 32'd0);
      chk("lu_w_pc_en", {31'd0, pc_en}, 32'd1);

      // rt path, Tuse 1: one stall against E, none against M (1 < 1 false).
      clear_d();
      d_rt = 5'd9; d_tuse_rt = 2'd1; e_wa = 5'd9; e_tnew = 2'd2; #1;
      chk("rt_e_stall", {31'd0, stall}, 32'd1);
      step(); e_wa = 5'd0; e_tnew = 2'd0; #1;
      chk("rt_m_stall", {31'd0, stall}, 32'd0);

      // Zero register never hazards.
      step(); clear_d();
      e_wa = 5'd0; e_tnew = 2'd2; d_rs = 5'd0; d_tuse_rs = 2'd0; #1;
      chk("zero_e_stall", {31'd0, stall}, 32'd0);
      step(); #1;
      chk("zero_m_stall", {31'd0, stall}, 32'd0);

      // Tuse 3 means not read.
      clear_d();
      e_wa = 5'd5; e_tnew = 2'd2; d_rs = 5'd5; d_rt = 5'd5; #1;
      chk("tuse3_stall", {31'd0, stall}, 32'd0);

      // Tnew 0 in E must stay 0 in M.
      step(); clear_d();
      e_wa = 5'd7; e_tnew = 2'd0; d_rs = 5'd7; d_tuse_rs = 2'd0; #1;
      chk("tnew0_e_stall", {31'd0, stall}, 32'd0);
      step(); e_wa = 5'd0; #1;
      chk("tnew0_m_stall", {31'd0, stall}, 32'd0);
      step(); clear_d(); #1;

      // Multiply with d_md_use held: six stall cycles, overlapping a data hazard.
      d_md_use = 1'b1; e_md_start = 1'b1; e_md_div = 1'b0; #1;
      chk("mul_t_busy", {31'd0, md_busy}, 32'd1);
      chk("mul_t_stall", {31'd0, stall}, 32'd1);
      chk("mul_t_state", {30'd0, md_state}, 32'd0);
      for (int k = 1; k <= 5; k++) begin
         step();
         e_md_start = 1'b0;
         if (k == 2) begin
            e_wa = 5'd3; e_tnew = 2'd1; d_rs = 5'd3; d_tuse_rs = 2'd0;
         end else begin
            clear_d();
         end
         #1;
         chk($sformatf("mul_t%0d_state", k), {30'd0, md_state}, 32'd1);
         chk($sformatf("mul_t%0d_cnt", k), {28'd0, busy_cnt}, 32'(6 - k));
         chk($sformatf("mul_t%0d_stall", k), {31'd0, stall}, 32'd1);
      end
      step(); #1;
      chk("mul_t6_state", {30'd0, md_state}, 32'd0);
      chk("mul_t6_busy", {31'd0, md_busy}, 32'd0);
      chk("mul_t6_stall", {31'd0, stall}, 32'd0);
`ifdef PIPE_STALL_CNT_EN
      chk("stall_count", stall_count, 32'd9);
`else
      chk("stall_count", stall_count, 32'd0);
`endif
      d_md_use = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
